// File: rtl/writeback_regfile.sv
// writeback_regfile: Y86-64 PIPE writeback stage with register file, status tracking and retire counter.
// Optional macro WB_READ_BYPASS_EN adds same-cycle write-through on the decode read ports.
module writeback_regfile #(
    parameter logic [63:0] RSP_INIT = 64'd1000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             W_stall,
    input  logic [2:0]       W_stat,
    input  logic [3:0]       W_icode,
    input  logic [63:0]      W_valE,
    input  logic [63:0]      W_valM,
    input  logic [3:0]       W_dstE,
    input  logic [3:0]       W_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    output logic [2:0]       Stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] HALTED = 2'd1;
    localparam logic [1:0] FAULT  = 2'd2;
    localparam logic [3:0] RNONE  = 4'hF;

    // Entry 15 exists only so any 4-bit source indexes safely; it stays zero.
    logic [63:0] regs [0:15];
    logic [1:0]  state;
    logic        retire;
    logic        is_aok;
    logic        is_hlt;
    logic        unused_icode;

    assign unused_icode = ^W_icode;
    assign retire = (state == RUN) && !W_stall && (W_stat != 3'd0);
    assign is_aok = W_stat == 3'd1;
    assign is_hlt = W_stat == 3'd2;
    assign halted = state != RUN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= (i == 4) ? RSP_INIT : 64'd0;
            state   <= RUN;
            Stat    <= 3'd1;
            retired <= '0;
        end else if (retire) begin
            // valM takes priority so popq %rsp leaves the popped value in %rsp.
            if (is_aok)
                for (int i = 0; i < 15; i++)
                    if (W_dstM == 4'(i))
                        regs[i] <= W_valM;
                    else if (W_dstE == 4'(i))
                        regs[i] <= W_valE;
            if (is_aok || is_hlt)
                retired <= retired + CNT_W'(1);
            if (is_hlt) begin
                state <= HALTED;
                Stat  <= 3'd2;
            end else if (!is_aok) begin
                state <= FAULT;
                Stat  <= (W_stat == 3'd3) ? 3'd3 : 3'd4;
            end
        end
    end

`ifdef WB_READ_BYPASS_EN
    logic wr_ok;
    assign wr_ok = retire && is_aok;
    assign d_rvalA = (d_srcA == RNONE) ? 64'd0 :
                     (wr_ok && d_srcA == W_dstM) ? W_valM :
                     (wr_ok && d_srcA == W_dstE) ? W_valE : regs[d_srcA];
    assign d_rvalB = (d_srcB == RNONE) ? 64'd0 :
                     (wr_ok && d_srcB == W_dstM) ? W_valM :
                     (wr_ok && d_srcB == W_dstE) ? W_valE : regs[d_srcB];
`else
    assign d_rvalA = (d_srcA == RNONE) ? 64'd0 : regs[d_srcA];
    assign d_rvalB = (d_srcB == RNONE) ? 64'd0 : regs[d_srcB];
`endif
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed vector table plus hand sequences for reset, fault, bypass and counter wrap.
module tb_writeback_regfile;
    localparam int CW = 4;

    logic          clk = 0, rst = 0;
    logic          W_stall = 0;
    logic [2:0]    W_stat = 0;
    logic [3:0]    W_icode = 0;
    logic [63:0]   W_valE = 0, W_valM = 0;
    logic [3:0]    W_dstE = 4'hF, W_dstM = 4'hF, d_srcA = 4'hF, d_srcB = 4'hF;
    logic [63:0]   d_rvalA, d_rvalB;
    logic [2:0]    Stat;
    logic          halted;
    logic [CW-1:0] retired;
    int            n_cmp = 0, n_bad = 0;

    writeback_regfile #(.RSP_INIT(64'd1000), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .W_stall(W_stall), .W_stat(W_stat), .W_icode(W_icode),
        .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
        .Stat(Stat), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [2:0]  stat;
        logic [3:0]  dste;
        logic [63:0] vale;
        logic [3:0]  dstm;
        logic [63:0] valm;
        logic [3:0]  sa, sb;
        logic [63:0] ea, eb;
        logic [2:0]  est;
        logic        eh;
        logic [3:0]  eret;
    } vec_t;

    vec_t vecs [0:8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic [2:0] stat, input logic [3:0] dste,
                         input logic [63:0] vale, input logic [3:0] dstm, input logic [63:0] valm);
        W_stall = stall; W_stat = stat; W_dstE = dste; W_valE = vale; W_dstM = dstm; W_valM = valm;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        #1;
        rst = 0;
        drive(0, 0, 4'hF, 0, 4'hF, 0);
    endtask

    task automatic check_status(input string tag, input logic [2:0] est, input logic eh, input logic [3:0] eret);
        chk({tag, "_stat"}, 64'(Stat), 64'(est));
        chk({tag, "_halted"}, 64'(halted), 64'(eh));
        chk({tag, "_retired"}, 64'(retired), 64'(eret));
    endtask

    initial begin
        vecs[0] = '{0, 3'd1, 4'd2, 64'h55, 4'd3, 64'hAA, 4'd2, 4'd3, 64'h55, 64'hAA, 3'd1, 0, 4'd1};
        vecs[1] = '{0, 3'd1, 4'd4, 64'h10, 4'd4, 64'h20, 4'd4, 4'hF, 64'h20, 64'h0, 3'd1, 0, 4'd2};
        vecs[2] = '{0, 3'd0, 4'd1, 64'h7, 4'hF, 64'h0, 4'd1, 4'd2, 64'h0, 64'h55, 3'd1, 0, 4'd2};
        vecs[3] = '{1, 3'd1, 4'd1, 64'h7, 4'hF, 64'h0, 4'd1, 4'd3, 64'h0, 64'hAA, 3'd1, 0, 4'd2};
        vecs[4] = '{0, 3'd1, 4'hF, 64'h9, 4'd1, 64'h77, 4'd1, 4'hF, 64'h77, 64'h0, 3'd1, 0, 4'd3};
        vecs[5] = '{0, 3'd1, 4'd14, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 64'h0, 4'd14, 4'd0,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd1, 0, 4'd4};
        vecs[6] = '{0, 3'd2, 4'd5, 64'h9, 4'hF, 64'h0, 4'd5, 4'd2, 64'h0, 64'h55, 3'd2, 1, 4'd5};
        vecs[7] = '{0, 3'd1, 4'd5, 64'h9, 4'hF, 64'h0, 4'd5, 4'd1, 64'h0, 64'h77, 3'd2, 1, 4'd5};
        vecs[8] = '{0, 3'd3, 4'd6, 64'h3, 4'hF, 64'h0, 4'd6, 4'd4, 64'h0, 64'h20, 3'd2, 1, 4'd5};

        #12;
        rst = 1;
        #2;
        rst = 0;
        for (int r = 0; r < 16; r++) begin
            d_srcA = 4'(r);
            #1;
            chk($sformatf("reset_reg%0d", r), d_rvalA, (r == 4) ? 64'd1000 : 64'd0);
        end
        check_status("reset", 3'd1, 0, 4'd0);

        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            drive(vecs[k].stall, vecs[k].stat, vecs[k].dste, vecs[k].vale, vecs[k].dstm, vecs[k].valm);
            @(posedge clk);
            #1;
            drive(0, 0, 4'hF, 0, 4'hF, 0);
            d_srcA = vecs[k].sa;
            d_srcB = vecs[k].sb;
            #1;
            chk($sformatf("vec%0d_rvalA", k), d_rvalA, vecs[k].ea);
            chk($sformatf("vec%0d_rvalB", k), d_rvalB, vecs[k].eb);
            check_status($sformatf("vec%0d", k), vecs[k].est, vecs[k].eh, vecs[k].eret);
        end

        // Mid-cycle async reset clears the halted state and every register at once.
        do_reset();
        d_srcA = 4'd2;
        d_srcB = 4'd4;
        #1;
        chk("rst2_reg2", d_rvalA, 64'd0);
        chk("rst2_reg4", d_rvalB, 64'd1000);
        check_status("rst2", 3'd1, 0, 4'd0);

        drive(0, 3'd3, 4'd6, 64'h66, 4'hF, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 4'hF, 0, 4'hF, 0);
        d_srcA = 4'd6;
        #1;
        chk("adr_reg6", d_rvalA, 64'd0);
        check_status("adr", 3'd3, 1, 4'd0);

        do_reset();
        drive(0, 3'd7, 4'd6, 64'h66, 4'hF, 0);
        @(posedge clk);
        #1;
        check_status("badstat", 3'd4, 1, 4'd0);

        do_reset();
        d_srcA = 4'd7;
        drive(0, 3'd1, 4'd7, 64'h123, 4'hF, 0);
        #1;
`ifdef WB_READ_BYPASS_EN
        chk("bypass_pre", d_rvalA, 64'h123);
`else
        chk("nobypass_pre", d_rvalA, 64'h0);
`endif
        @(posedge clk);
        #1;
        drive(0, 0, 4'hF, 0, 4'hF, 0);
        #1;
        chk("post_edge_reg7", d_rvalA, 64'h123);
        check_status("after_rst_run", 3'd1, 0, 4'd1);

        // 16 more retires wrap the 4-bit counter back to 1.
        drive(0, 3'd1, 4'hF, 0, 4'hF, 0);
        repeat (16) @(posedge clk);
        #1;
        drive(0, 0, 4'hF, 0, 4'hF, 0);
        check_status("wrap", 3'd1, 0, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Final pipeline stage of the Y86-64 PIPE core; consumes the W-register outputs of the memory stage.
- Holds the architectural register file (15 x 64-bit, IDs 0-14, ID 4'hF = RNONE) and performs both writebacks each cycle.
- Serves the two combinational read ports used by decode.
- Tracks processor status (AOK/HLT/ADR/INS), freezes state on halt or fault, and counts retired instructions.

Parameters:
- RSP_INIT, 64'd1000, reset value of %rsp (register 4); sits inside the 1024-byte data memory.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- W_stall  in  1  when 1, W contents are not retired this cycle.
- W_stat  in  3  status of the instruction in W: 0 = BUB, 1 = AOK, 2 = HLT, 3 = ADR, 4 = INS.
- W_icode  in  4  icode of the instruction in W.
- W_valE  in  64  ALU result to write to W_dstE.
- W_valM  in  64  memory read result to write to W_dstM.
- W_dstE  in  4  destination register for valE; 4'hF = none.
- W_dstM  in  4  destination register for valM; 4'hF = none.
- d_srcA  in  4  decode read address A.
- d_srcB  in  4  decode read address B.
- d_rvalA  out  64  register file value for d_srcA.
- d_rvalB  out  64  register file value for d_srcB.
- Stat  out  3  architectural status.
- halted  out  1  high in HALTED or FAULT; upstream fetch uses it to stop.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, rst=1):
  - All registers cleared to 0, except reg 4, which is set to RSP_INIT.
  - state = RUN, Stat = 1 (AOK), halted = 0, retired = 0.
- States:
  - RUN: normal operation.
  - HALTED: entered on a retired HLT.
  - FAULT: entered on a retired ADR or INS.
  - HALTED and FAULT are terminal until rst.
- Retire condition: state == RUN, W_stall == 0, and W_stat != BUB.
- On posedge with the retire condition true:
  - W_stat == AOK:
    - write W_valE to reg[W_dstE] if W_dstE != F.
    - write W_valM to reg[W_dstM] if W_dstM != F.
    - retired increments by 1.
  - W_stat == HLT: no register writes; retired increments by 1; state -> HALTED; Stat = 2.
  - W_stat == ADR or INS: no register writes; retired unchanged; state -> FAULT; Stat = W_stat.
  - W_stat outside 0-4: treated as INS (Stat = 4, FAULT).
- Dual write to the same register (W_dstE == W_dstM != F): valM wins (popq %rsp semantics).
- Bubble (W_stat == 0) or W_stall == 1: no writes, no count, state and Stat hold.
- In HALTED or FAULT: all writes and counting suppressed regardless of inputs; Stat and halted stay sticky.
- Read ports are combinational from current register contents:
  - src == F returns 64'd0.
  - Write latency: one cycle; a value written at posedge N is visible on the read ports after edge N.
- retired wraps modulo 2^CNT_W with no flag.
- rst asserted mid-operation: immediate clear regardless of clk; a write at a coincident edge is lost.
- W_icode is informational only; it does not gate writes, since dst fields are already RNONE where no write applies.

Optional Feature:
- Macro: WB_READ_BYPASS_EN.
- Defined: same-cycle write-through bypass on the read ports.
  - If the retire condition holds with W_stat == AOK and d_srcX equals W_dstM, d_rvalX = W_valM.
  - Otherwise, if d_srcX equals W_dstE, d_rvalX = W_valE.
  - Otherwise, the register file value.
  - Never bypasses when src == F.
- Undefined: read ports reflect register contents only; decode's forwarding logic covers the W stage.

Test Plan:
1. Reset check: pulse rst mid-cycle -> all reads return 0 except d_srcA = 4, which returns 1000; Stat = 1; halted = 0; retired = 0.
2. Dual write: W_stat = 1, W_dstE = 2, W_valE = 0x55, W_dstM = 3, W_valM = 0xAA, one edge -> reg2 = 0x55, reg3 = 0xAA, retired = 1. Repeat with W_dstE = W_dstM = 4 (valE 0x10, valM 0x20) -> reg4 = 0x20.
3. Bubble and stall suppression: W_stat = 0, W_dstE = 1, W_valE = 7 -> reg1 stays 0, retired unchanged. Then W_stat = 1 with W_stall = 1 -> no write, retired unchanged.
4. Halt is sticky: retire HLT -> Stat = 2, halted = 1, retired += 1. A following AOK write to reg5 = 9 is ignored, reg5 stays 0, and retired is frozen.
5. Fault: W_stat = 3 with W_dstE = 6 -> Stat = 3, halted = 1, reg6 unchanged, retired unchanged. Then rst -> state returns to RUN.
6. WB_READ_BYPASS_EN defined: d_srcA = 7, W_dstE = 7, W_valE = 0x123, AOK, before the edge -> d_rvalA = 0x123 combinationally. Undefined: d_rvalA shows the old value, and shows 0x123 after the edge.
